// File: rtl/cpu_pkg.sv
// Shared types and defaults for the register-file write arbitration path.
package cpu_pkg;

    localparam int DATA_W_DEF       = 32;
    localparam int ADDR_W_DEF       = 5;
    localparam int DEPTH_DEF        = 2;
    localparam int STARVE_LIMIT_DEF = 4;
    localparam int REG_ZERO         = 0;

    typedef enum logic {
        PIPE_PRI = 1'b0,
        MD_PRI   = 1'b1
    } arb_state_t;

endpackage

// File: rtl/wb_result_fifo.sv
// Small result FIFO for mul/div writebacks; exposes per-entry valid and
// destination address so the hazard lookup can see every queued entry.
module wb_result_fifo
    import cpu_pkg::*;
#(
    parameter int DEPTH  = DEPTH_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int WIDTH  = ADDR_W_DEF + DATA_W_DEF
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  logic                   pop,
    input  logic [WIDTH-1:0]       push_data,
    output logic [WIDTH-1:0]       head_data,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count,
    output logic [DEPTH-1:0]       entry_valid,
    output logic [ADDR_W-1:0]      entry_addr [DEPTH]
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [CNT_W-1:0] count_reg;
    logic             do_push;
    logic             do_pop;

    assign full      = (count_reg == CNT_W'(DEPTH));
    assign empty     = (count_reg == '0);
    assign count     = count_reg;
    assign do_push   = push && !full;
    assign do_pop    = pop && !empty;
    assign head_data = mem[rd_ptr_reg];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + CNT_W'(1);
                2'b01:   count_reg <= count_reg - CNT_W'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr_reg] <= push_data;
    end

    // Push and pop never target the same slot: that would need count 0 or DEPTH.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
        logic valid_reg;

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                valid_reg <= 1'b0;
            end else if (do_push && wr_ptr_reg == PTR_W'(gi)) begin
                valid_reg <= 1'b1;
            end else if (do_pop && rd_ptr_reg == PTR_W'(gi)) begin
                valid_reg <= 1'b0;
            end
        end

        assign entry_valid[gi] = valid_reg;
        assign entry_addr[gi]  = mem[gi][WIDTH-1 -: ADDR_W];
    end

endmodule

// File: rtl/regwrite_arbiter.sv
// Arbitrates the single register-file write port between pipeline writeback
// and queued mul/div results, forcing a drain when queued results starve.
module regwrite_arbiter
    import cpu_pkg::*;
#(
    parameter int DATA_W       = DATA_W_DEF,
    parameter int ADDR_W       = ADDR_W_DEF,
    parameter int DEPTH        = DEPTH_DEF,
    parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wb_valid,
    output logic              wb_ready,
    input  logic [ADDR_W-1:0] wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    input  logic              md_valid,
    output logic              md_ready,
    input  logic [ADDR_W-1:0] md_addr,
    input  logic [DATA_W-1:0] md_data,
    input  logic [ADDR_W-1:0] pend_addr,
    output logic              pend_hit,
    output logic              write_reg,
    output logic [ADDR_W-1:0] dstreg_addr,
    output logic [DATA_W-1:0] dstreg_data
);

    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam int SC_W  = $clog2(STARVE_LIMIT + 1);

    arb_state_t        state_reg;
    arb_state_t        state_next;
    logic [SC_W-1:0]   starve_cnt_reg;
    logic [SC_W-1:0]   starve_cnt_next;

    logic              fifo_full;
    logic              fifo_empty;
    logic [CNT_W-1:0]  fifo_count;
    logic [ADDR_W-1:0] head_addr;
    logic [DATA_W-1:0] head_data;
    logic [DEPTH-1:0]  entry_valid;
    logic [ADDR_W-1:0] entry_addr [DEPTH];
    logic [DEPTH-1:0]  hit_vec;

    logic              push;
    logic              pop;
    logic              grant_wb;
    logic [ADDR_W-1:0] grant_addr;
    logic [DATA_W-1:0] grant_data;

    assign md_ready = !fifo_full;
    assign push     = md_valid && md_ready;

    wb_result_fifo #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .WIDTH  (ADDR_W + DATA_W)
    ) u_fifo (
        .clk         (clk),
        .reset       (reset),
        .push        (push),
        .pop         (pop),
        .push_data   ({md_addr, md_data}),
        .head_data   ({head_addr, head_data}),
        .full        (fifo_full),
        .empty       (fifo_empty),
        .count       (fifo_count),
        .entry_valid (entry_valid),
        .entry_addr  (entry_addr)
    );

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_hit
        assign hit_vec[gi] = entry_valid[gi] && (entry_addr[gi] == pend_addr);
    end
    assign pend_hit = (pend_addr != ADDR_W'(REG_ZERO)) && (|hit_vec);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg      <= PIPE_PRI;
            starve_cnt_reg <= '0;
        end else begin
            state_reg      <= state_next;
            starve_cnt_reg <= starve_cnt_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            PIPE_PRI: begin
                if ((grant_wb && !fifo_empty && starve_cnt_reg == SC_W'(STARVE_LIMIT - 1)) ||
                    (fifo_full && md_valid))
                    state_next = MD_PRI;
            end
            MD_PRI: begin
                if (fifo_empty || (fifo_count == CNT_W'(1) && !push))
                    state_next = PIPE_PRI;
            end
            default: state_next = PIPE_PRI;
        endcase
    end

    always_comb begin
        wb_ready = 1'b1;
        grant_wb = 1'b0;
        pop      = 1'b0;
        case (state_reg)
            PIPE_PRI: begin
                wb_ready = 1'b1;
                grant_wb = wb_valid;
                pop      = !wb_valid && !fifo_empty;
            end
            MD_PRI: begin
                wb_ready = fifo_empty;
                grant_wb = wb_valid && fifo_empty;
                pop      = !fifo_empty;
            end
            default: ;
        endcase
    end

    // Saturates so a stale count cannot wrap back below the limit.
    always_comb begin
        starve_cnt_next = starve_cnt_reg;
        if (pop || fifo_empty)
            starve_cnt_next = '0;
        else if (grant_wb && starve_cnt_reg != SC_W'(STARVE_LIMIT))
            starve_cnt_next = starve_cnt_reg + SC_W'(1);
    end

    assign grant_addr = grant_wb ? wb_addr : head_addr;
    assign grant_data = grant_wb ? wb_data : head_data;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            write_reg   <= 1'b0;
            dstreg_addr <= '0;
            dstreg_data <= '0;
        end else if (grant_wb || pop) begin
            write_reg   <= (grant_addr != ADDR_W'(REG_ZERO));
            dstreg_addr <= grant_addr;
            dstreg_data <= grant_data;
        end else begin
            write_reg   <= 1'b0;
        end
    end

endmodule
